npc_unit: RTL
=============

# npc_unit

Parametrised fetch-address generator for the MIPS pipeline. It holds the architectural fetch PC register and computes the next PC from D-stage control transfers, exception entry and `eret`. A one-entry pending-redirect buffer keeps taken redirects that arrive while the fetch side is held. It replaces the purely combinational next-PC selector in the F stage and drives instruction memory and F-stage exception logic.

## Interface
Parameters:
- `ADDR_W`, 32: PC width. Must be at least `IDX_W+6`.
- `OFF_W`, 16: width of the branch offset.
- `IDX_W`, 26: width of the jump index.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_PC`, 32'h0000_4180: exception entry vector.
- `IMEM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IMEM_HI`, 32'h0000_6FFF: highest legal fetch address.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  D-stage hazard stall. F and D are frozen and the D control inputs are ignored.
- `f_hold`  in  1  fetch-side hold, e.g. imem not ready. F is frozen while D advances.
- `br_type`  in  2  D-stage transfer: 00 none, 01 conditional branch, 10 jump-immediate, 11 jump-register.
- `br_cond`  in  1  branch condition from the D comparator. Only meaningful when `br_type`=01.
- `d_pc`  in  `ADDR_W`  PC of the D-stage instruction.
- `d_imm`  in  `OFF_W`  signed word offset.
- `d_index`  in  `IDX_W`  jump index.
- `d_rs`  in  `ADDR_W`  register target for jump-register.
- `exc_req`  in  1  exception or interrupt redirect.
- `eret_req`  in  1  return from exception.
- `epc`  in  `ADDR_W`  return address for `eret`.
- `pc`  out  `ADDR_W`  current fetch PC (registered).
- `npc`  out  `ADDR_W`  value `pc` takes at the next edge (combinational).
- `pend_v`  out  1  pending redirect valid (registered).
- `adel`  out  1  fetch address error for the current `pc` (combinational from `pc`).

## Operation
Target arithmetic, all modulo 2^`ADDR_W`:
- Conditional: `d_pc + 4 + (sext(d_imm) << 2)`.
- Jump-immediate: `{(d_pc+4)[ADDR_W-1:IDX_W+2], d_index, 2'b00}`. The upper bits come from `d_pc+4`, not from the instruction word.
- Jump-register: `d_rs`, used unmodified.
- A taken transfer T exists when `br_type` is 10 or 11, or when `br_type`=01 and `br_cond`=1.

Next-state priority, evaluated each edge; the first matching rule applies:
1. `exc_req`: redirect R=`EXC_PC`.
2. `eret_req`: redirect R=`epc`.
3. `stall`: hold `pc` and the pending buffer.
4. T exists: redirect R=T.
5. `f_hold`: hold everything.
6. `pend_v`: `pc`<=`pend`, `pend_v`<=0.
7. Otherwise `pc`<=`pc`+4.

Redirect R (rules 1, 2, 4):
- If `f_hold`=1: `pend`<=R, `pend_v`<=1, `pc` held.
- Otherwise: `pc`<=R, `pend_v`<=0.
- A newer redirect always overwrites an older pending entry.

Other rules:
- `exc_req` and `eret_req` act even while `stall`=1. If both are high, `exc_req` wins.
- `adel`=1 when any of these hold: `pc[1:0]`≠0, `pc`<`IMEM_LO`, `pc`>`IMEM_HI`. `adel` does not alter sequencing; the exception comes back through `exc_req`.
- `npc` equals exactly the value rules 1–7 would load. With `f_hold`=1, `npc`=`pc`.

## Timing
- Reset, asynchronous: `pc`=`RESET_PC`, `pend`=0, `pend_v`=0. `npc`=`RESET_PC`+4 once `reset` deasserts with no other input active. `adel`=0 at the default parameters.
- Reset mid-hold discards the pending entry.
- Redirect latency: 1 edge when the fetch side is free. When held, the redirect appears at the first edge after `f_hold` falls, unless rules 1–4 preempt it at that edge.
- Delay slot: the instruction at `d_pc+4` is already in F when T is accepted and is not squashed by this block.
- A pending entry survives any number of `stall` cycles.

## Test plan
1. Reset with idle inputs for 3 edges -> `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `adel`=0.
2. Conditional branch: `d_pc`=0x3004, `d_imm`=16'hFFFE, `br_cond`=1, no holds -> next `pc`=0x3000. Same stimulus with `br_cond`=0 -> `pc`+4.
3. Jump-immediate: `d_pc`=0x0FFF_FFFC, `d_index`=26'h0000C00 -> `pc`=0x1000_3000 (upper bits from `d_pc`+4). Jump-register: `d_rs`=0x3402 -> `pc`=0x3402, `adel`=1.
4. Jump-register to 0x3100 while `f_hold`=1 for 3 cycles -> `pc` held, `pend_v`=1, `pend`=0x3100. The first edge after `f_hold` falls gives `pc`=0x3100 and `pend_v`=0.
5. `exc_req` and `eret_req` together with `stall`=1 -> `pc`=0x4180. `eret_req` alone with `epc`=0x3050 -> `pc`=0x3050.
6. Pending 0x3100 held, then `exc_req` while `f_hold`=1 -> `pend`=0x4180. Asserting `reset` during the hold -> `pc`=0x3000 and `pend_v`=0 immediately.

Source files
------------

// File: rtl/npc_unit.sv
// npc_unit: fetch-address generator for the MIPS pipeline.
//
// Holds the architectural fetch PC and computes the next PC. The next PC
// comes from exception entry, eret, D-stage control transfers, or
// sequential fetch. A one-entry pending buffer keeps a taken redirect
// that arrives while the fetch side is held.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   stall     in   D-stage hazard stall (F and D frozen, D controls ignored)
//   f_hold    in   fetch-side hold (F frozen, D advances)
//   br_type   in   00 none, 01 cond branch, 10 jump-imm, 11 jump-reg
//   br_cond   in   branch condition (only used for br_type 01)
//   d_pc      in   PC of the D-stage instruction
//   d_imm     in   signed word offset
//   d_index   in   jump index
//   d_rs      in   jump-register target
//   exc_req   in   exception / interrupt redirect
//   eret_req  in   return from exception
//   epc       in   eret return address
//   pc        out  current fetch PC (registered)
//   npc       out  value pc takes at the next edge (combinational)
//   pend_v    out  pending redirect valid (registered)
//   adel      out  fetch address error for the current pc
module npc_unit #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 16,
  parameter int IDX_W  = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_PC   = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IMEM_HI  = 32'h0000_6FFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              f_hold,
  input  logic [1:0]        br_type,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [OFF_W-1:0]  d_imm,
  input  logic [IDX_W-1:0]  d_index,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              pend_v,
  output logic              adel
);

  localparam int SEXT_W = ADDR_W - OFF_W;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JIMM = 2'b10;
  localparam logic [1:0] BR_JREG = 2'b11;

  logic [ADDR_W-1:0] pend_q;
  logic [ADDR_W-1:0] pend_nxt;
  logic              pend_v_nxt;

  logic [ADDR_W-1:0] d_pc4;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] xfer_tgt;
  logic              taken;
  logic              redir_v;
  logic [ADDR_W-1:0] redir_tgt;

  // Transfer targets. The jump region bits come from the delay-slot
  // address (d_pc+4), not from the jump instruction's own address.
  assign d_pc4   = d_pc + ADDR_W'(4);
  assign off_ext = {{SEXT_W{d_imm[OFF_W-1]}}, d_imm} << 2;
  assign br_tgt  = d_pc4 + off_ext;
  assign j_tgt   = {d_pc4[ADDR_W-1:IDX_W+2], d_index, 2'b00};

  always_comb begin
    xfer_tgt = d_rs;
    taken    = 1'b0;
    case (br_type)
      BR_NONE: begin
        xfer_tgt = d_rs;
        taken    = 1'b0;
      end
      BR_COND: begin
        xfer_tgt = br_tgt;
        taken    = br_cond;
      end
      BR_JIMM: begin
        xfer_tgt = j_tgt;
        taken    = 1'b1;
      end
      BR_JREG: begin
        xfer_tgt = d_rs;
        taken    = 1'b1;
      end
      default: begin
        xfer_tgt = d_rs;
        taken    = 1'b0;
      end
    endcase
  end

  // exc/eret act regardless of stall; D-stage transfers only when D advances.
  always_comb begin
    redir_v   = 1'b0;
    redir_tgt = xfer_tgt;
    if (exc_req) begin
      redir_v   = 1'b1;
      redir_tgt = EXC_PC;
    end else if (eret_req) begin
      redir_v   = 1'b1;
      redir_tgt = epc;
    end else if (!stall && taken) begin
      redir_v   = 1'b1;
      redir_tgt = xfer_tgt;
    end
  end

  // A redirect under f_hold parks in the pending buffer (overwriting any
  // older entry) and pc stays put; otherwise it loads pc directly.
  always_comb begin
    npc        = pc;
    pend_nxt   = pend_q;
    pend_v_nxt = pend_v;
    if (redir_v) begin
      if (f_hold) begin
        pend_nxt   = redir_tgt;
        pend_v_nxt = 1'b1;
      end else begin
        npc        = redir_tgt;
        pend_v_nxt = 1'b0;
      end
    end else if (!stall && !f_hold) begin
      if (pend_v) begin
        npc        = pend_q;
        pend_v_nxt = 1'b0;
      end else begin
        npc = pc + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      pc     <= npc;
      pend_q <= pend_nxt;
      pend_v <= pend_v_nxt;
    end
  end

  assign adel = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

endmodule
